pipe_ripple_adder: RTL
======================

PIPE_RIPPLE_ADDER -- requirements
Module: pipe_ripple_adder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-003 Parameter SEG, default 8, SHALL set the bits added per pipeline stage.
REQ-004 The derived constant STAGES = WIDTH/SEG SHALL be the pipeline depth.
REQ-005 Port clk  input  1  SHALL be the rising-edge clock.
REQ-006 Port rst  input  1  SHALL be the synchronous active-high reset.
REQ-007 Port in_valid  input  1  SHALL indicate that the operands are presented.
REQ-008 Port in_ready  output  1  SHALL indicate that the block accepts the operands this cycle.
REQ-009 Port a  input  WIDTH  SHALL carry operand A.
REQ-010 Port b  input  WIDTH  SHALL carry operand B.
REQ-011 Port cin  input  1  SHALL carry the carry-in, used in add mode only.
REQ-012 Port sub  input  1  SHALL select the operation: 0 = A+B+cin, 1 = A-B.
REQ-013 Port out_valid  output  1  SHALL indicate that the result is valid.
REQ-014 Port out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-015 Port sum  output  WIDTH  SHALL carry the result.
REQ-016 Port cout  output  1  SHALL carry the carry-out; in sub mode, 1 means no borrow.
REQ-017 Port ovf  output  1  SHALL carry the two's-complement signed overflow flag.

Function
REQ-018 A transfer SHALL occur on a clk edge when in_valid and in_ready are both 1.
REQ-019 An output transfer SHALL occur on a clk edge when out_valid and out_ready are both 1.
REQ-020 Global advance enable SHALL be en = !(out_valid && !out_ready).
  - in_ready SHALL equal en.
  - All stages SHALL shift only when en = 1.
REQ-021 In sub mode the block SHALL invert b and force the carry-in to 1; cin SHALL be ignored.
REQ-022 Stage k (0..STAGES-1) SHALL add bits [k*SEG +: SEG] using the registered carry from stage k-1.
  - Stage 0 SHALL use the effective carry-in.
  - Operand slices not yet consumed SHALL travel in pipeline registers alongside the data.
  - Result slices already computed SHALL travel in pipeline registers alongside the data.
REQ-023 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid = 1 when no stall occurs.
REQ-024 Throughput SHALL be one operation per cycle while out_ready = 1.
REQ-025 The final stage carry SHALL drive cout.
REQ-026 ovf SHALL be the XOR of the carry into the MSB and the carry out of the MSB.
REQ-027 Each stage SHALL carry a valid bit; a bubble (valid = 0) SHALL propagate without affecting other stages.
REQ-028 While stalled (en = 0), sum, cout, ovf and out_valid SHALL hold stable, and no transfer SHALL be lost.
REQ-029 Results SHALL emerge in acceptance order.
REQ-030 The case WIDTH = SEG SHALL be legal and SHALL give latency 1.
REQ-031 WIDTH not divisible by SEG, or SEG < 1, SHALL fail at elaboration.
REQ-032 Result arithmetic SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-033 Reset SHALL have priority over the handshake in any cycle in which rst = 1.
REQ-034 On the clk edge with rst = 1, all stage valid bits SHALL clear.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - Operations in flight SHALL be discarded and SHALL never emerge.
REQ-035 in_ready SHALL be 1 in the cycle after reset, since out_valid = 0.
REQ-036 Operands presented while rst = 1 SHALL NOT be accepted.

Structure
REQ-037 The shared package pipe_adder_pkg SHALL hold the defaults WIDTH_DEF = 32 and SEG_DEF = 8.
REQ-038 The shared package pipe_adder_pkg SHALL hold the op encoding OP_ADD = 0 and OP_SUB = 1.
REQ-039 Combinational sub-module seg_adder SHALL implement one SEG-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, c_out, c_msb_in.
  - Built from the existing Full_Adder cell.
  - Instantiated STAGES times.

Verification
REQ-040 The bench SHALL cover the following scenarios, each with WIDTH = 32, SEG = 8:
  - Add wrap: a=0xFFFFFFFF, b=1, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x00000000, cout=1, ovf=0.
  - Subtract with borrow: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - Signed overflow: a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
  - Carry-in: a=2, b=3, cin=1, sub=0 -> sum=6, cout=0.
  - Backpressure: four back-to-back ops (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles starting when the first result appears.
    - Required: in_ready=0 and sum held at 2 throughout the stall.
    - Required: afterwards 2, 4, 6, 8 emerge in order with none lost.
  - Reset mid-stream: two ops in flight, rst=1 for one edge -> next cycle out_valid=0, in_ready=1; neither result ever appears.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// ============================================================================
// Module      : pipe_adder_pkg
// Description : Shared defaults and operation encoding for the pipelined adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_adder_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEG_DEF   = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : pipe_adder_pkg

`default_nettype wire

// File: rtl/Full_Adder.sv
// ============================================================================
// Module      : Full_Adder
// Description : One-bit full adder cell used to build the ripple segments.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : Full_Adder

`default_nettype wire

// File: rtl/pipe_ripple_adder_seg_adder.sv
// ============================================================================
// Module      : seg_adder
// Description : Combinational SEG-bit ripple adder; also exposes the carry
//               into its top bit so the last segment can form signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_adder
  import pipe_adder_pkg::*;
#(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           c_out,
  output logic           c_msb_in
);

  logic [SEG:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    Full_Adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .sum  (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign c_out    = w_c[SEG];
  assign c_msb_in = w_c[SEG-1];

endmodule : seg_adder

`default_nettype wire

// File: rtl/pipe_ripple_adder.sv
// ============================================================================
// Module      : pipe_ripple_adder
// Description : WIDTH-bit add/subtract, SEG bits per pipeline stage, with a
//               valid/ready handshake and a single global advance enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ripple_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (SEG < 1) begin : g_bad_seg
    $error("pipe_ripple_adder: SEG must be at least 1");
  end else if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipe_ripple_adder: WIDTH must be a multiple of SEG");
  end

  localparam int STAGES = WIDTH / SEG;

  // Level k feeds stage k; operands shift right so each stage consumes the
  // low SEG bits, while the result accumulates from the top down.
  logic [WIDTH-1:0] r_opa [STAGES];
  logic [WIDTH-1:0] r_opb [STAGES];
  logic             r_cy  [STAGES+1];
  logic             r_v   [STAGES+1];
  logic [WIDTH-1:0] r_acc [1:STAGES];
  logic             r_ovf;

  logic [SEG-1:0]   w_s   [STAGES];
  logic             w_co  [STAGES];
  logic             w_cm  [STAGES];
  logic [WIDTH-1:0] w_acc [STAGES];
  logic             w_en;

  assign w_en     = !(r_v[STAGES] && !out_ready);
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    seg_adder #(
      .SEG (SEG)
    ) u_seg (
      .a        (r_opa[k][SEG-1:0]),
      .b        (r_opb[k][SEG-1:0]),
      .cin      (r_cy[k]),
      .s        (w_s[k]),
      .c_out    (w_co[k]),
      .c_msb_in (w_cm[k])
    );

    if (k == 0) begin : g_first
      assign w_acc[k] = WIDTH'(w_s[k]) << (WIDTH - SEG);
    end else begin : g_rest
      assign w_acc[k] = (r_acc[k] >> SEG) | (WIDTH'(w_s[k]) << (WIDTH - SEG));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_opa[k] <= '0;
        r_opb[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        r_cy[k] <= 1'b0;
        r_v[k]  <= 1'b0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        r_acc[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      // Subtraction is A + ~B + 1; cin is ignored in that mode.
      r_v[0]   <= in_valid;
      r_opa[0] <= a;
      r_opb[0] <= (sub == OP_SUB) ? ~b : b;
      r_cy[0]  <= (sub == OP_SUB) ? 1'b1 : cin;
      for (int k = 1; k < STAGES; k++) begin
        r_opa[k] <= r_opa[k-1] >> SEG;
        r_opb[k] <= r_opb[k-1] >> SEG;
      end
      for (int k = 1; k <= STAGES; k++) begin
        r_v[k]   <= r_v[k-1];
        r_cy[k]  <= w_co[k-1];
        r_acc[k] <= w_acc[k-1];
      end
      r_ovf <= w_co[STAGES-1] ^ w_cm[STAGES-1];
    end
  end

  assign out_valid = r_v[STAGES];
  assign sum       = r_acc[STAGES];
  assign cout      = r_cy[STAGES];
  assign ovf       = r_ovf;

endmodule : pipe_ripple_adder

`default_nettype wire
